// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES MixColumns types, constants and GF(2^8) helper
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  localparam int NCOL = 4;
  localparam int COL_W = 32;
  localparam logic [7:0] GF_POLY = 8'h1B;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_col_word.sv
// rtl/mix_col_word.sv - combinational 32-bit MixColumns column transform
// INV_MIX_EN adds the inv select for InvMixColumns.
import aes_pkg::*;

module mix_col_word (
  input  logic [COL_W-1:0] col,
`ifdef INV_MIX_EN
  input  logic             inv,
`endif
  output logic [COL_W-1:0] res
);

  logic [7:0] b  [4];
  logic [7:0] x2 [4];
`ifdef INV_MIX_EN
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
`endif

  // Byte 0 sits in the MSB of the column
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b[i]  = col[31-8*i -: 8];
      x2[i] = xtime(b[i]);
`ifdef INV_MIX_EN
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
`endif
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_byte
    localparam int J = (i + 1) % 4;
    localparam int K = (i + 2) % 4;
    localparam int L = (i + 3) % 4;
    logic [7:0] fwd;
    assign fwd = x2[i] ^ x2[J] ^ b[J] ^ b[K] ^ b[L];
`ifdef INV_MIX_EN
    logic [7:0] rev;
    assign rev = (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[J] ^ x2[J] ^ b[J])
               ^ (x8[K] ^ x4[K] ^ b[K]) ^ (x8[L] ^ b[L]);
    assign res[31-8*i -: 8] = inv ? rev : fwd;
`else
    assign res[31-8*i -: 8] = fwd;
`endif
  end

endmodule

// File: rtl/mix_col_sched.sv
// rtl/mix_col_sched.sv - sequences one shared column unit across a 128-bit AES state
// INV_MIX_EN adds the inv input selecting InvMixColumns per state.
import aes_pkg::*;

module mix_col_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef INV_MIX_EN
  input  logic         inv,
`endif
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  mc_state_t        state;
  logic [1:0]       col_cnt;
  logic [127:0]     src_reg;
  logic [127:0]     dst_reg;
  logic [COL_W-1:0] src_col;
  logic [COL_W-1:0] res_col;
`ifdef INV_MIX_EN
  logic             inv_reg;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign out_state = dst_reg;

  always_comb begin
    src_col = '0;
    case (col_cnt)
      2'd0: src_col = src_reg[127:96];
      2'd1: src_col = src_reg[95:64];
      2'd2: src_col = src_reg[63:32];
      2'd3: src_col = src_reg[31:0];
      default: src_col = '0;
    endcase
  end

  mix_col_word u_mix_col_word (
    .col (src_col),
`ifdef INV_MIX_EN
    .inv (inv_reg),
`endif
    .res (res_col)
  );

  // clear aborts without touching dst_reg, so out_state keeps its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col_cnt <= '0;
      src_reg <= '0;
      dst_reg <= '0;
`ifdef INV_MIX_EN
      inv_reg <= 1'b0;
`endif
    end else if (clear) begin
      state   <= IDLE;
      col_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state   <= RUN;
            src_reg <= in_state;
            col_cnt <= '0;
`ifdef INV_MIX_EN
            inv_reg <= inv;
`endif
          end
        end
        RUN: begin
          case (col_cnt)
            2'd0: dst_reg[127:96] <= res_col;
            2'd1: dst_reg[95:64]  <= res_col;
            2'd2: dst_reg[63:32]  <= res_col;
            2'd3: dst_reg[31:0]   <= res_col;
            default: ;
          endcase
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == 2'(NCOL - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_col_sched.sv
// tb/tb_mix_col_sched.sv - directed-vector bench for mix_col_sched (INV_MIX_EN adds inverse vector)
module tb_mix_col_sched;

  localparam logic [127:0] V1 = 128'hDB135345_F20A225C_01010101_C6C6C6C6;
  localparam logic [127:0] R1 = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;
  localparam logic [127:0] V2 = 128'hD4D4D4D5_2D26314C_00000000_FFFFFFFF;
  localparam logic [127:0] R2 = 128'hD5D5D7D6_4D7EBDF8_00000000_FFFFFFFF;
  localparam logic [127:0] JUNK = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         inv;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n;

  mix_col_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef INV_MIX_EN
    .inv       (inv),
`endif
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] v);
    in_valid = 1'b1;
    in_state = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; inv = 1'b0;
    clear = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // 1. FIPS-197 column vector, consumer always ready
    out_ready = 1'b1;
    send(V1);
    chk("t1_in_ready_run", in_ready, 0);
    chk("t1_busy_run", busy, 1);
    wait_valid(n);
    chk("t1_latency", n, 4);
    chk("t1_out_state", out_state, R1);
    tick();
    chk("t1_valid_width", out_valid, 0);
    chk("t1_in_ready_back", in_ready, 1);

    // 2. backpressure holds result stable
    out_ready = 1'b0;
    send(V2);
    wait_valid(n);
    chk("t2_latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_state", out_state, R2);
      chk("t2_hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    chk("t2_in_ready_pre", in_ready, 0);
    tick();
    chk("t2_in_ready_post", in_ready, 1);
    chk("t2_valid_drop", out_valid, 0);

    // 3. back-to-back with in_valid held; junk while busy must not be sampled
    in_valid = 1'b1;
    in_state = V1;
    tick();
    in_state = JUNK;
    wait_valid(n);
    chk("t3_latency_a", n, 4);
    chk("t3_out_a", out_state, R1);
    in_state = V2;
    tick();
    chk("t3_idle_gap", in_ready, 1);
    tick();
    chk("t3_second_accept", busy, 1);
    in_valid = 1'b0;
    wait_valid(n);
    chk("t3_latency_b", n, 4);
    chk("t3_out_b", out_state, R2);
    tick();

    // 4. clear on the second RUN cycle leaves column 1 untouched
    send(V1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_in_ready", in_ready, 1);
    chk("t4_busy", busy, 0);
    chk("t4_out_state_kept", out_state, {R1[127:96], R2[95:0]});
    for (int i = 0; i < 5; i++) begin
      chk("t4_no_valid", out_valid, 0);
      tick();
    end
    send(V2);
    wait_valid(n);
    chk("t4_latency", n, 4);
    chk("t4_out_state", out_state, R2);
    tick();

    // 5. asynchronous reset while in DONE
    out_ready = 1'b0;
    send(V1);
    wait_valid(n);
    chk("t5_reach_done", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_state", out_state, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    chk("t5_rst_busy", busy, 0);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(V2);
    wait_valid(n);
    chk("t5_latency", n, 4);
    chk("t5_out_state", out_state, R2);
    tick();

`ifdef INV_MIX_EN
    // 6. inverse transform restores the FIPS input
    inv = 1'b1;
    send(R1);
    inv = 1'b0;
    wait_valid(n);
    chk("t6_latency", n, 4);
    chk("t6_out_state", out_state, V1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
